serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//
// Bit-serial adder with its own control FSM. An accepted start captures both
// operands and the carry-in, then a single 1-bit full adder processes one bit
// per clock, LSB first, for WIDTH cycles. The final sum and carry-out are loaded
// into the output registers on the DONE-entry edge. They hold that value until
// the next addition completes.
//
// Ports
//   clk    in   1      clock, all state updates on the rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      begin an addition (sampled only in IDLE)
//   a      in   WIDTH  operand A, captured on the accepted start edge
//   b      in   WIDTH  operand B, captured on the accepted start edge
//   cin    in   1      carry-in, captured on the accepted start edge
//   busy   out  1      high while the serial addition is running
//   done   out  1      one-cycle pulse when s/cout hold a new result
//   s      out  WIDTH  sum of the last completed addition
//   cout   out  1      carry-out of the last completed addition

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    // One extra bit over log2 so the counter never wraps inside an operation.
    localparam int unsigned   CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;

    // The only adder in the design: one full-adder cell on the operand LSBs.
    logic sum_bit;
    logic carry_bit;

    always_comb begin
        sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
        carry_bit = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Sum bits enter from the MSB side so bit 0 ends up at res[0]
                // after WIDTH shifts.
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                carry_d = carry_bit;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    s_d     = {sum_bit, res_q[WIDTH-1:1]};
                    cout_d  = carry_bit;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    // Status outputs are decoded straight from the state flops.
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
        s    = s_q;
        cout = cout_q;
    end

endmodule
